// File: rtl/pc_gen_if.sv
// ============================================================================
//  Module      : pc_gen_if
//  Description : Control and fetch-address bundle between the hazard, branch
//                and CSR logic (master) and the PC generator (slave).
//                The o_misalign signal exists only when PC_GEN_MISALIGN_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_gen_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic            i_stall;
  logic            i_trap;
  logic [XLEN-1:0] i_trap_vec;
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_call;
  logic [XLEN-1:0] i_call_ret_pc;
  logic            i_ret;
  logic [XLEN-1:0] o_pc;
  logic            o_pc_valid;
  logic [CW-1:0]   o_ras_count;
  logic            o_ras_empty;
`ifdef PC_GEN_MISALIGN_EN
  logic            o_misalign;
`endif

  // Control side: drives requests, observes the fetch address
  modport master (
    output i_stall, i_trap, i_trap_vec, i_redirect, i_redirect_pc,
    output i_call, i_call_ret_pc, i_ret,
    input  o_pc, o_pc_valid, o_ras_count, o_ras_empty
`ifdef PC_GEN_MISALIGN_EN
    , input o_misalign
`endif
  );

  // PC generator side
  modport slave (
    input  i_stall, i_trap, i_trap_vec, i_redirect, i_redirect_pc,
    input  i_call, i_call_ret_pc, i_ret,
    output o_pc, o_pc_valid, o_ras_count, o_ras_empty
`ifdef PC_GEN_MISALIGN_EN
    , output o_misalign
`endif
  );

endinterface

`default_nettype wire

// File: rtl/pc_gen.sv
// ============================================================================
//  Module      : pc_gen
//  Description : Program-counter generator for the IF stage. Registered next
//                PC with priority trap > redirect > stall > RAS return
//                prediction > sequential increment, plus a circular
//                return-address stack that overwrites its oldest entry on
//                overflow.
//                Optional macro PC_GEN_MISALIGN_EN adds o_misalign, flagging
//                a trap/redirect target whose low two bits were non-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              INC          = 4,
  parameter int              RAS_DEPTH    = 4   // power of 2, >= 2
) (
  input  logic     i_clk,
  input  logic     i_reset,
  pc_gen_if.slave  bus
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [CW-1:0]   c_ras_full  = CW'(RAS_DEPTH);
  localparam logic [XLEN-1:0] c_inc       = XLEN'(INC);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;     // next free slot; top lives at r_ptr-1
  logic [CW-1:0]   r_count;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic            w_q;
  logic            w_has_entry;
  logic [PW-1:0]   w_top_idx;
  logic [XLEN-1:0] w_ras_top;
  logic            w_push;
  logic            w_pop;
  logic            w_swap;
  logic [XLEN-1:0] w_trap_tgt;
  logic [XLEN-1:0] w_redir_tgt;
  logic [XLEN-1:0] w_pc_next;
  logic [PW-1:0]   w_ptr_next;
  logic [CW-1:0]   w_count_next;

  // Aligned redirect targets: instructions are always word aligned here
  assign w_trap_tgt  = {bus.i_trap_vec[XLEN-1:2], 2'b00};
  assign w_redir_tgt = {bus.i_redirect_pc[XLEN-1:2], 2'b00};

  // RAS is only touched by an instruction that is really advancing fetch
  assign w_q         = ~bus.i_stall & ~bus.i_trap & ~bus.i_redirect & r_valid;
  assign w_has_entry = (r_count != '0);
  assign w_top_idx   = r_ptr - PW'(1);
  assign w_ras_top   = r_ras[w_top_idx];

  // Call+ret on an empty stack degenerates into a plain push
  assign w_push = w_q & bus.i_call & (~bus.i_ret | ~w_has_entry);
  assign w_pop  = w_q & bus.i_ret & ~bus.i_call & w_has_entry;
  assign w_swap = w_q & bus.i_call & bus.i_ret & w_has_entry;

  // Next-PC selection in priority order
  always_comb begin
    w_pc_next = r_pc;
    if (!r_valid) begin
      w_pc_next = r_pc;               // first edge after reset holds the vector
    end else if (bus.i_trap) begin
      w_pc_next = w_trap_tgt;
    end else if (bus.i_redirect) begin
      w_pc_next = w_redir_tgt;
    end else if (bus.i_stall) begin
      w_pc_next = r_pc;
    end else if (bus.i_ret && w_has_entry) begin
      w_pc_next = w_ras_top;
    end else begin
      w_pc_next = r_pc + c_inc;       // natural wrap modulo 2^XLEN
    end
  end

  // Next RAS pointer and occupancy; a swap leaves both unchanged
  always_comb begin
    w_ptr_next   = r_ptr;
    w_count_next = r_count;
    if (w_push) begin
      w_ptr_next   = r_ptr + PW'(1);
      w_count_next = (r_count == c_ras_full) ? r_count : r_count + CW'(1);
    end else if (w_pop) begin
      w_ptr_next   = w_top_idx;
      w_count_next = r_count - CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // PC and valid flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_valid <= 1'b1;
    end
  end

  // RAS pointer and occupancy
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_ptr   <= w_ptr_next;
      r_count <= w_count_next;
    end
  end

  // RAS storage: push writes the free slot, swap rewrites the top in place
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push) begin
      r_ras[r_ptr] <= bus.i_call_ret_pc;
    end else if (w_swap) begin
      r_ras[w_top_idx] <= bus.i_call_ret_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Optional misaligned-target flag
  // --------------------------------------------------------------------------
`ifdef PC_GEN_MISALIGN_EN
  logic r_misalign;
  logic w_misalign_next;

  // Flag follows whichever target actually won the PC mux this edge
  always_comb begin
    w_misalign_next = 1'b0;
    if (r_valid) begin
      if (bus.i_trap) begin
        w_misalign_next = (bus.i_trap_vec[1:0] != 2'b00);
      end else if (bus.i_redirect) begin
        w_misalign_next = (bus.i_redirect_pc[1:0] != 2'b00);
      end
    end
  end

  // Misalign flag registered alongside the PC
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_misalign_next;
    end
  end

  assign bus.o_misalign = r_misalign;
`else
  // Low target bits are simply discarded when the flag is not built
  logic w_unused_low_bits;
  assign w_unused_low_bits = ^{bus.i_trap_vec[1:0], bus.i_redirect_pc[1:0]};
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.o_pc        = r_pc;
  assign bus.o_pc_valid  = r_valid;
  assign bus.o_ras_count = r_count;
  assign bus.o_ras_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
//  Module      : tb_pc_gen
//  Description : Self-checking bench for pc_gen: a queue-based reference
//                model compared every cycle, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

  localparam int          XLEN = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV   = 32'h0000_0100;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pc_gen_if #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .INC(4), .RAS_DEPTH(DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stack as a bounded queue, newest at the back
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_ras[$];
  bit          m_q;
  bit          m_mis;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    = RV;
      m_valid = 0;
      m_mis   = 0;
      m_ras.delete();
    end else if (!m_valid) begin
      m_valid = 1;
      m_mis   = 0;
    end else begin
      m_q = !bus.i_stall && !bus.i_trap && !bus.i_redirect;
      m_mis = 0;
      if (bus.i_trap) begin
        m_pc  = bus.i_trap_vec & ~32'h3;
        m_mis = (bus.i_trap_vec % 4) != 0;
      end else if (bus.i_redirect) begin
        m_pc  = bus.i_redirect_pc & ~32'h3;
        m_mis = (bus.i_redirect_pc % 4) != 0;
      end else if (bus.i_stall) begin
        m_pc = m_pc;
      end else if (bus.i_ret && m_ras.size() > 0) begin
        m_pc = m_ras[m_ras.size()-1];
      end else begin
        m_pc = m_pc + 32'd4;
      end
      if (m_q) begin
        if (bus.i_call && bus.i_ret && m_ras.size() > 0) begin
          m_ras[m_ras.size()-1] = bus.i_call_ret_pc;
        end else if (bus.i_call) begin
          m_ras.push_back(bus.i_call_ret_pc);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (bus.i_ret && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("model_pc",    64'(bus.o_pc),        64'(m_pc));
    chk("model_valid", 64'(bus.o_pc_valid),  64'(m_valid));
    chk("model_count", 64'(bus.o_ras_count), 64'(m_ras.size()));
    chk("model_empty", 64'(bus.o_ras_empty), 64'(m_ras.size() == 0));
`ifdef PC_GEN_MISALIGN_EN
    chk("model_misalign", 64'(bus.o_misalign), 64'(m_mis));
`endif
  end

  // Apply one cycle of inputs, then look just after the edge
  task automatic step(input bit st, input bit tr, input bit rd, input bit ca, input bit re,
                      input logic [31:0] tv, input logic [31:0] rp, input logic [31:0] cp);
    bus.i_stall       = st;
    bus.i_trap        = tr;
    bus.i_redirect    = rd;
    bus.i_call        = ca;
    bus.i_ret         = re;
    bus.i_trap_vec    = tv;
    bus.i_redirect_pc = rp;
    bus.i_call_ret_pc = cp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();              step(0,0,0,0,0, 0, 0, 0);  endtask
  task automatic call(input logic [31:0] cp); step(0,0,0,1,0, 0, 0, cp); endtask
  task automatic ret();               step(0,0,0,0,1, 0, 0, 0);  endtask
  task automatic redir(input logic [31:0] rp); step(0,0,1,0,0, 0, rp, 0); endtask

  task automatic chk_pc(input string name, input logic [31:0] exp);
    chk(name, 64'(bus.o_pc), 64'(exp));
  endtask

  task automatic chk_cnt(input string name, input int exp);
    chk(name, 64'(bus.o_ras_count), 64'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_stall = 0; bus.i_trap = 0; bus.i_redirect = 0;
    bus.i_call = 0;  bus.i_ret = 0;
    bus.i_trap_vec = '0; bus.i_redirect_pc = '0; bus.i_call_ret_pc = '0;
    #1;
    chk_pc("reset_pc", RV);
    chk("reset_valid", 64'(bus.o_pc_valid), 64'd0);
    chk_cnt("reset_count", 0);
    chk("reset_empty", 64'(bus.o_ras_empty), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Release: vector held for one edge, then sequential
    idle(); chk_pc("rel_pc0", 32'h100); chk("rel_valid", 64'(bus.o_pc_valid), 64'd1);
    idle(); chk_pc("rel_pc1", 32'h104);
    idle(); chk_pc("rel_pc2", 32'h108);

    // Stall hold
    redir(32'h20); chk_pc("redir_20", 32'h20);
    for (int i = 0; i < 3; i++) begin
      step(1,0,0,0,0, 0, 0, 0); chk_pc("stall_hold", 32'h20);
    end
    idle(); chk_pc("stall_release", 32'h24);

    // Priority and alignment
    step(1,1,1,0,0, 32'h80, 32'h40, 0); chk_pc("trap_priority", 32'h80);
    redir(32'h43); chk_pc("redir_align", 32'h40);

    // RAS round trip
    call(32'h10); chk_pc("call_seq", 32'h44); chk_cnt("cnt1", 1);
    call(32'h20);
    call(32'h30); chk_cnt("cnt3", 3);
    ret(); chk_pc("ret_30", 32'h30);
    ret(); chk_pc("ret_20", 32'h20);
    ret(); chk_pc("ret_10", 32'h10);
    chk("ras_empty", 64'(bus.o_ras_empty), 64'd1);
    ret(); chk_pc("ret_empty_seq", 32'h14);

    // Overflow drops the oldest entry
    call(32'h4); call(32'h8); call(32'hC); call(32'h10); call(32'h14);
    chk_cnt("ovf_cnt", 4);
    ret(); chk_pc("ovf_14", 32'h14);
    ret(); chk_pc("ovf_10", 32'h10);
    ret(); chk_pc("ovf_0c", 32'hC);
    ret(); chk_pc("ovf_08", 32'h8);
    chk_cnt("ovf_drained", 0);
    ret(); chk_pc("ovf_seq", 32'hC);

    // Simultaneous call and return
    call(32'h10); call(32'h20); call(32'h30);
    step(0,0,0,1,1, 0, 0, 32'h50); chk_pc("callret_pc", 32'h30); chk_cnt("callret_cnt", 3);
    ret(); chk_pc("callret_next", 32'h50); chk_cnt("callret_cnt2", 2);
    step(1,0,0,1,1, 0, 0, 32'h60); chk_pc("stall_callret_hold", 32'h50);
    chk_cnt("stall_callret_cnt", 2);
    ret(); chk_pc("stall_callret_next", 32'h20);

    // Trap keeps RAS contents
    step(0,1,0,0,0, 32'h200, 0, 0); chk_pc("trap_200", 32'h200); chk_cnt("trap_keep", 1);
    ret(); chk_pc("trap_keep_ret", 32'h10);

    // Call+ret on empty stack acts as a push
    step(0,0,0,1,1, 0, 0, 32'h90); chk_pc("empty_callret_seq", 32'h14); chk_cnt("empty_callret_cnt", 1);
    ret(); chk_pc("empty_callret_ret", 32'h90);

    // Misaligned redirect with stack interaction ignored
    redir(32'h0000_0302); chk_pc("redir_302", 32'h300);

    // Wrap at all-ones
    redir(32'hFFFF_FFFC); chk_pc("wrap_top", 32'hFFFF_FFFC);
    idle(); chk_pc("wrap_zero", 32'h0);

    // Asynchronous reset in the middle of a cycle
    call(32'h70); chk_cnt("pre_rst_cnt", 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_pc("async_rst_pc", RV);
    chk("async_rst_valid", 64'(bus.o_pc_valid), 64'd0);
    chk_cnt("async_rst_cnt", 0);
    @(negedge clk);
    rst = 1'b0;
    idle(); chk_pc("rerel_pc0", 32'h100);
    idle(); chk_pc("rerel_pc1", 32'h104);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the 5-stage RISC-V pipeline; feeds the IF stage.
- Extends a plain PC register with the following:
  - configurable width and reset vector;
  - stall hold;
  - prioritised trap and branch redirect;
  - a circular return-address stack (RAS) that predicts return targets.
- Sits between hazard/branch/CSR logic and the instruction-memory address port.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- INC, 4, sequential PC increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; must be a power of 2 and at least 2.
- CW, $clog2(RAS_DEPTH+1), derived localparam: width of the RAS occupancy count.

Ports:
- i_clk, input, 1, clock, rising edge.
- i_reset, input, 1, reset; asynchronous, active-high.
- i_stall, input, 1, hold PC (load-use hazard or memory wait).
- i_trap, input, 1, take trap this cycle.
- i_trap_vec, input, XLEN, trap target.
- i_redirect, input, 1, branch/jump resolved mispredict.
- i_redirect_pc, input, XLEN, corrected target.
- i_call, input, 1, call decoded; push i_call_ret_pc.
- i_call_ret_pc, input, XLEN, return address to push.
- i_ret, input, 1, return decoded; predict from RAS top.
- o_pc, output, XLEN, current fetch PC.
- o_pc_valid, output, 1, fetch address valid.
- o_ras_count, output, CW, RAS occupancy.
- o_ras_empty, output, 1, o_ras_count == 0.

Behaviour:
- Reset (async, i_reset=1):
  - o_pc = RESET_VECTOR.
  - o_pc_valid = 0.
  - RAS pointer = 0, count = 0, entries cleared to 0.
- o_pc_valid is set on the first rising edge with i_reset=0 and stays 1 until the next reset.
- Next-PC priority, evaluated each rising edge; all PC updates are registered with 1-cycle latency:
  1. i_trap: o_pc <= {i_trap_vec[XLEN-1:2], 2'b00}.
  2. i_redirect: o_pc <= {i_redirect_pc[XLEN-1:2], 2'b00}.
  3. i_stall: o_pc holds.
  4. i_ret with RAS non-empty: o_pc <= RAS top.
  5. Otherwise: o_pc <= o_pc + INC, modulo 2^XLEN (wraps at all-ones).
- Before o_pc_valid is set (first edge after reset release), o_pc holds RESET_VECTOR.
- RAS operations are qualified by q = ~i_stall & ~i_trap & ~i_redirect & o_pc_valid. When q=0, i_call/i_ret have no effect.
- Push (q & i_call & ~i_ret):
  - write i_call_ret_pc at ptr, then ptr <= ptr+1 (mod RAS_DEPTH);
  - count <= min(count+1, RAS_DEPTH).
  - When full, the push overwrites the oldest entry and count stays RAS_DEPTH.
- Pop (q & i_ret & ~i_call):
  - if count > 0: top = entry[ptr-1], ptr <= ptr-1, count <= count-1;
  - if count == 0: no pop, and the PC takes the sequential path.
- Simultaneous call and ret (q & i_call & i_ret):
  - predicted PC = current top, provided count > 0;
  - top entry is replaced with i_call_ret_pc; ptr and count unchanged;
  - if count == 0, this acts as a plain push.
- Trap or redirect does not flush the RAS; its contents are preserved.
- Reset asserted mid-operation returns every register to its reset value immediately, regardless of the clock.

Optional Feature:
- Macro: PC_GEN_MISALIGN_EN.
- Defined:
  - extra output o_misalign (1 bit, reset 0);
  - registered with the PC update: o_misalign = 1 on the edge where a trap or redirect target has bits[1:0] != 0, otherwise 0;
  - target is still force-aligned as above.
- Undefined: port absent; no additional logic.

Test Plan:
- Reset then release, no other inputs, XLEN=32, RESET_VECTOR=0x100:
  - o_pc sequence is 0x100, 0x100, 0x104, 0x108;
  - o_pc_valid rises after the first edge following release.
- i_stall=1 for 3 cycles at PC 0x20 -> o_pc stays 0x20; next edge after stall drops gives 0x24.
- Same edge i_trap=1 (vec 0x80), i_redirect=1 (pc 0x40), i_stall=1 -> o_pc=0x80. Redirect alone with pc 0x43 -> o_pc=0x40.
- RAS round trip:
  - push 0x10, 0x20, 0x30 (count=3), then i_ret three times;
  - o_pc = 0x30, 0x20, 0x10 and o_ras_empty=1;
  - a fourth i_ret gives the sequential PC.
- RAS overflow, RAS_DEPTH=4: push 0x4..0x14 (5 pushes) -> count=4; pops return 0x14, 0x10, 0xC, 0x8.
- i_call with i_call_ret_pc=0x50 and i_ret together, top=0x30 -> o_pc=0x30, count unchanged, next i_ret gives 0x50. Same inputs with i_stall=1 -> RAS unchanged.
